// File: rtl/perf_mon_pkg.sv
// Shared definitions for the checkbits run-timer.
// Holds the monitor FSM state encoding and the default marker values that
// firmware writes onto the checkbits field around each FIR run.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

  // Must match the firmware header values.
  localparam logic [15:0] DEF_START_MARK = 16'h00A5;
  localparam logic [15:0] DEF_END_MARK   = 16'hBF5A;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter used to time one run.
// Ports:
//   axis_clk    clock
//   axis_rst_n  asynchronous active-low reset (count -> 0)
//   clear       synchronous clear, wins over inc
//   inc         advance count by one, holding at all-ones
//   count       current count
//   at_max      count is all-ones; a further increment would saturate
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

  assign at_max = &count;

endmodule

// File: rtl/checkbits_perf_monitor.sv
// Run-timer for the firmware checkbits field (mprj_io[31:16]).
// Registers checkbits once, opens a run on START_MARK, closes it on END_MARK
// and stores the elapsed cycle count in one of NUM_RUNS result slots.
// Ports:
//   axis_clk, axis_rst_n  clock, asynchronous active-low reset
//   clear                 sync clear of results/flags/run index; FSM re-arms
//   enable                0 parks the FSM in IDLE (DONE is kept)
//   checkbits             marker field from firmware GPIO writes
//   busy                  a run is being timed
//   run_valid             1-cycle pulse when a result slot is written
//   run_idx, run_cycles   slot and value of the most recent write
//   all_done, overflow    sticky: all slots filled / some run saturated
//   rd_idx, rd_data       combinational result readback, 0 when out of range
module checkbits_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter logic [15:0] START_MARK = DEF_START_MARK,
  parameter logic [15:0] END_MARK   = DEF_END_MARK,
  parameter int          NUM_RUNS   = 3,
  parameter int          CNT_W      = 32,
  localparam int         IDX_W      = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [15:0]      checkbits,
  output logic             busy,
  output logic             run_valid,
  output logic [IDX_W-1:0] run_idx,
  output logic [CNT_W-1:0] run_cycles,
  output logic             all_done,
  output logic             overflow,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RUNS - 1);
  localparam logic [31:0]      NUM_RUNS_U = NUM_RUNS;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [15:0]      chk_q;
  mon_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] results [NUM_RUNS];
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_max;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             end_seen;

  assign end_seen  = (chk_q == END_MARK);
  // The counter sits at zero whenever no run is open, so entering COUNT
  // starts from 0 without an explicit load.
  assign cnt_clear = clear || (state != ST_COUNT);
  assign cnt_inc   = (state == ST_COUNT) && !end_seen;

  perf_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .count      (cnt),
    .at_max     (cnt_at_max)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      chk_q      <= '0;
      state      <= ST_IDLE;
      idx        <= '0;
      run_valid  <= 1'b0;
      run_idx    <= '0;
      run_cycles <= '0;
      all_done   <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_RUNS; i++) results[i] <= '0;
    end else begin
      // Stage boundary: checkbits capture; the FSM below only looks at chk_q.
      chk_q     <= checkbits;
      run_valid <= 1'b0;
      if (clear) begin
        idx        <= '0;
        run_idx    <= '0;
        run_cycles <= '0;
        all_done   <= 1'b0;
        overflow   <= 1'b0;
        for (int i = 0; i < NUM_RUNS; i++) results[i] <= '0;
        state <= enable ? ST_ARMED : ST_IDLE;
      end else if (!enable && (state != ST_DONE)) begin
        // Partial run is dropped; idx stays so the slot is reused.
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARMED;
          ST_ARMED: begin
            if (chk_q == START_MARK) state <= ST_COUNT;
          end
          ST_COUNT: begin
            // The END cycle itself is part of the run, hence cnt+1.
            if (cnt_at_max) overflow <= 1'b1;
            if (end_seen) begin
              results[idx] <= sat_inc(cnt);
              run_cycles   <= sat_inc(cnt);
              run_idx      <= idx;
              run_valid    <= 1'b1;
              if (idx == LAST_IDX) begin
                all_done <= 1'b1;
                state    <= ST_DONE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ST_ARMED;
              end
            end
          end
          default: state <= ST_DONE;
        endcase
      end
    end
  end

  assign busy = (state == ST_COUNT);

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_RUNS_U) rd_data = results[rd_idx];
  end

endmodule

// File: tb/tb_checkbits_perf_monitor.sv
module tb_checkbits_perf_monitor;

  localparam logic [15:0] START_V = 16'h00A5;
  localparam logic [15:0] END_V   = 16'hBF5A;
  localparam logic [15:0] IDLE_V  = 16'h1234;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] checkbits = IDLE_V;
  logic [1:0]  rd_idx = 2'd0;

  logic        busy, run_valid, all_done, overflow;
  logic [1:0]  run_idx;
  logic [31:0] run_cycles, rd_data;

  logic        busy8, run_valid8, all_done8, overflow8;
  logic [1:0]  run_idx8;
  logic [7:0]  run_cycles8, rd_data8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  checkbits_perf_monitor u_dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .clear      (clear),
    .enable     (enable),
    .checkbits  (checkbits),
    .busy       (busy),
    .run_valid  (run_valid),
    .run_idx    (run_idx),
    .run_cycles (run_cycles),
    .all_done   (all_done),
    .overflow   (overflow),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  checkbits_perf_monitor #(.CNT_W(8)) u_dut8 (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .clear      (clear),
    .enable     (enable),
    .checkbits  (checkbits),
    .busy       (busy8),
    .run_valid  (run_valid8),
    .run_idx    (run_idx8),
    .run_cycles (run_cycles8),
    .all_done   (all_done8),
    .overflow   (overflow8),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset both monitors, then enable; returns with the FSM in ARMED.
  task automatic do_reset;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; checkbits = IDLE_V; rd_idx = 2'd0;
    tick; tick;
    rst_n = 1'b1; enable = 1'b1;
    tick;
  endtask

  // START sampled at edge N, END sampled at edge N+len; returns just after edge N+len.
  task automatic drive_run(input int len);
    checkbits = START_V;
    tick;
    checkbits = IDLE_V;
    repeat (len - 1) tick;
    checkbits = END_V;
    tick;
    checkbits = IDLE_V;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0;
    tick; tick;
    checks++;
    if ({busy, run_valid, all_done, overflow} !== 4'b0 || run_idx !== 2'd0 || run_cycles !== 32'd0)
      begin errors++; $display("FAIL reset_outputs: busy=%b vld=%b done=%b ovf=%b idx=%0d cyc=%0d, want all 0",
        busy, run_valid, all_done, overflow, run_idx, run_cycles); end
    checks++;
    if (rd_data !== 32'd0 || rd_data8 !== 8'd0 || overflow8 !== 1'b0)
      begin errors++; $display("FAIL reset_results: rd_data=%0d rd_data8=%0d ovf8=%b, want 0", rd_data, rd_data8, overflow8); end
  endtask

  task automatic test_single_run;
    do_reset;
    drive_run(10);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b want 1", busy); end
    tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd0 || run_cycles !== 32'd10)
      begin errors++; $display("FAIL single_pulse: vld=%b idx=%0d cyc=%0d want 1/0/10", run_valid, run_idx, run_cycles); end
    tick;
    checks++;
    if (run_valid !== 1'b0 || busy !== 1'b0 || run_cycles !== 32'd10)
      begin errors++; $display("FAIL single_after: vld=%b busy=%b cyc=%0d want 0/0/10", run_valid, busy, run_cycles); end
    rd_idx = 2'd0; #1;
    checks++;
    if (rd_data !== 32'd10) begin errors++; $display("FAIL single_rd0: rd_data=%0d want 10", rd_data); end
  endtask

  task automatic test_three_runs;
    int lens [3] = '{10, 893, 2541};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive_run(lens[i]);
      tick;
      checks++;
      if (run_valid !== 1'b1 || run_idx !== 2'(i) || run_cycles !== 32'(lens[i]))
        begin errors++; $display("FAIL three_pulse%0d: vld=%b idx=%0d cyc=%0d want 1/%0d/%0d",
          i, run_valid, run_idx, run_cycles, i, lens[i]); end
    end
    checks++;
    if (all_done !== 1'b1) begin errors++; $display("FAIL three_all_done: all_done=%b want 1", all_done); end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i); #1;
      checks++;
      if (rd_data !== 32'(lens[i])) begin errors++; $display("FAIL three_rd%0d: rd_data=%0d want %0d", i, rd_data, lens[i]); end
    end
    rd_idx = 2'd3; #1;
    checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL three_rd_oob: rd_data=%0d want 0", rd_data); end
    // Fourth run must be ignored in DONE.
    drive_run(10);
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (run_valid !== 1'b0 || busy !== 1'b0 || run_idx !== 2'd2 || run_cycles !== 32'd2541 || all_done !== 1'b1)
        begin errors++; $display("FAIL three_fourth_ignored: vld=%b busy=%b idx=%0d cyc=%0d done=%b want 0/0/2/2541/1",
          run_valid, busy, run_idx, run_cycles, all_done); end
    end
    rd_idx = 2'd0; #1;
    checks++;
    if (rd_data !== 32'd10) begin errors++; $display("FAIL three_rd0_kept: rd_data=%0d want 10", rd_data); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    checkbits = START_V; tick;
    checkbits = IDLE_V;  repeat (9) tick;
    checkbits = END_V;   tick;
    checkbits = START_V; tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd0 || run_cycles !== 32'd10)
      begin errors++; $display("FAIL b2b_first: vld=%b idx=%0d cyc=%0d want 1/0/10", run_valid, run_idx, run_cycles); end
    checkbits = IDLE_V; repeat (6) tick;
    checkbits = END_V;  tick;
    checkbits = IDLE_V; tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd1 || run_cycles !== 32'd7)
      begin errors++; $display("FAIL b2b_second: vld=%b idx=%0d cyc=%0d want 1/1/7", run_valid, run_idx, run_cycles); end
  endtask

  task automatic test_saturation;
    do_reset;
    drive_run(300);
    tick;
    checks++;
    if (run_valid8 !== 1'b1 || run_cycles8 !== 8'd255 || overflow8 !== 1'b1)
      begin errors++; $display("FAIL sat_w8: vld=%b cyc=%0d ovf=%b want 1/255/1", run_valid8, run_cycles8, overflow8); end
    checks++;
    if (run_cycles !== 32'd300 || overflow !== 1'b0)
      begin errors++; $display("FAIL sat_w32: cyc=%0d ovf=%b want 300/0", run_cycles, overflow); end
    drive_run(5);
    tick;
    checks++;
    if (run_valid8 !== 1'b1 || run_cycles8 !== 8'd5 || run_idx8 !== 2'd1 || overflow8 !== 1'b1)
      begin errors++; $display("FAIL sat_sticky: vld=%b cyc=%0d idx=%0d ovf=%b want 1/5/1/1",
        run_valid8, run_cycles8, run_idx8, overflow8); end
  endtask

  task automatic test_clear_on_end;
    do_reset;
    drive_run(10);
    tick;
    drive_run(10);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if (run_valid !== 1'b0 || run_idx !== 2'd0 || run_cycles !== 32'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL clear_end: vld=%b idx=%0d cyc=%0d busy=%b want 0/0/0/0",
        run_valid, run_idx, run_cycles, busy); end
    rd_idx = 2'd0; #1;
    checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL clear_results: rd_data=%0d want 0", rd_data); end
    tick;
    checks++;
    if (run_valid !== 1'b0) begin errors++; $display("FAIL clear_no_late_pulse: vld=%b want 0", run_valid); end
    drive_run(4);
    tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd0 || run_cycles !== 32'd4)
      begin errors++; $display("FAIL clear_rearmed: vld=%b idx=%0d cyc=%0d want 1/0/4", run_valid, run_idx, run_cycles); end
  endtask

  task automatic test_async_reset;
    do_reset;
    drive_run(10);
    tick;
    checkbits = START_V; tick;
    checkbits = IDLE_V;  repeat (4) tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: busy=%b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    rd_idx = 2'd0; #1;
    checks++;
    if (busy !== 1'b0 || run_idx !== 2'd0 || run_cycles !== 32'd0 || rd_data !== 32'd0)
      begin errors++; $display("FAIL areset_cleared: busy=%b idx=%0d cyc=%0d rd0=%0d want 0/0/0/0",
        busy, run_idx, run_cycles, rd_data); end
    #1 rst_n = 1'b1;
    tick;
    drive_run(10);
    tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd0 || run_cycles !== 32'd10)
      begin errors++; $display("FAIL areset_rerun: vld=%b idx=%0d cyc=%0d want 1/0/10", run_valid, run_idx, run_cycles); end
  endtask

  task automatic test_enable_drop;
    do_reset;
    checkbits = START_V; tick;
    checkbits = IDLE_V;  repeat (3) tick;
    enable = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL enable_drop_busy: busy=%b want 0", busy); end
    enable = 1'b1;
    tick;
    drive_run(6);
    tick;
    checks++;
    if (run_valid !== 1'b1 || run_idx !== 2'd0 || run_cycles !== 32'd6)
      begin errors++; $display("FAIL enable_rerun: vld=%b idx=%0d cyc=%0d want 1/0/6", run_valid, run_idx, run_cycles); end
  endtask

  initial begin
    test_reset;
    test_single_run;
    test_three_runs;
    test_back_to_back;
    test_saturation;
    test_clear_on_end;
    test_async_reset;
    test_enable_drop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
